// File: rtl/mod_det3x3_ctrl.sv
// Shared arithmetic units plus the 3x3 determinant sequencer.
// Arithmetic is LARGURA-bit two's complement and wraps modulo 2^LARGURA.

// 2x2 determinant m00*m11 - m01*m10, truncated to LARGURA bits.
// Latency: combinational.
// Backpressure: none; the output follows the inputs.
module mod_determinante_2x2 #(
    parameter int LARGURA = 8
) (
    input  logic [LARGURA-1:0] m00,
    input  logic [LARGURA-1:0] m01,
    input  logic [LARGURA-1:0] m10,
    input  logic [LARGURA-1:0] m11,
    output logic [LARGURA-1:0] det
);
    assign det = m00 * m11 - m01 * m10;
endmodule

// Wrapping multiplier that keeps the low LARGURA bits of x*y.
// Latency: combinational.
// Backpressure: none; the output follows the inputs.
module mod_mult #(
    parameter int LARGURA = 8
) (
    input  logic [LARGURA-1:0] x,
    input  logic [LARGURA-1:0] y,
    output logic [LARGURA-1:0] p
);
    assign p = x * y;
endmodule

// 3x3 determinant by cofactor expansion along row 0, one minor per cycle.
// Latency: start sampled at edge k gives a done pulse in the cycle after edge k+3.
// Backpressure: start is ignored while busy or in FIM; nothing is queued.
module mod_det3x3_ctrl #(
    parameter int LARGURA = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [9*LARGURA-1:0]   matriz,
    output logic                   busy,
    output logic                   done,
    output logic [LARGURA-1:0]     resultado
);
    localparam int L = LARGURA;

    typedef enum logic [2:0] {OCIOSO, C0, C1, C2, FIM} estado_t;

    estado_t           estado;
    logic [9*L-1:0]    mat_q;
    logic [L-1:0]      acc;
    logic [L-1:0]      ea, eb, ec, ed, ee, ef, eg, eh, ei;
    logic [L-1:0]      m00, m01, m10, m11, menor;
    logic [L-1:0]      fator, prod;

    assign ea = mat_q[9*L-1:8*L];
    assign eb = mat_q[8*L-1:7*L];
    assign ec = mat_q[7*L-1:6*L];
    assign ed = mat_q[6*L-1:5*L];
    assign ee = mat_q[5*L-1:4*L];
    assign ef = mat_q[4*L-1:3*L];
    assign eg = mat_q[3*L-1:2*L];
    assign eh = mat_q[2*L-1:L];
    assign ei = mat_q[L-1:0];

    // Each step pairs one row-0 coefficient with the minor of its column.
    always_comb begin
        m00   = '0;
        m01   = '0;
        m10   = '0;
        m11   = '0;
        fator = '0;
        case (estado)
            C0: begin m00 = ee; m01 = ef; m10 = eh; m11 = ei; fator = ea; end
            C1: begin m00 = ed; m01 = ef; m10 = eg; m11 = ei; fator = eb; end
            C2: begin m00 = ed; m01 = ee; m10 = eg; m11 = eh; fator = ec; end
            default: ;
        endcase
    end

    mod_determinante_2x2 #(.LARGURA(L)) u_det2 (
        .m00 (m00),
        .m01 (m01),
        .m10 (m10),
        .m11 (m11),
        .det (menor)
    );

    mod_mult #(.LARGURA(L)) u_mult (
        .x (fator),
        .y (menor),
        .p (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= OCIOSO;
            mat_q     <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            resultado <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (start) begin
                        mat_q  <= matriz;
                        acc    <= '0;
                        busy   <= 1'b1;
                        estado <= C0;
                    end
                end
                C0: begin
                    acc    <= prod;
                    estado <= C1;
                end
                C1: begin
                    acc    <= acc - prod;
                    estado <= C2;
                end
                C2: begin
                    resultado <= acc + prod;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    estado    <= FIM;
                end
                FIM: begin
                    done   <= 1'b0;
                    estado <= OCIOSO;
                end
                default: begin
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    estado <= OCIOSO;
                end
            endcase
        end
    end
endmodule
